// File: rtl/shifter_arbiter_pkg.sv
// Shared encodings and helpers for the two-requester shifter arbiter.
package shifter_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic CTL_ARITH = 1'b0;
  localparam logic CTL_LOGIC = 1'b1;
  localparam logic CTL_LEFT  = 1'b0;
  localparam logic CTL_RIGHT = 1'b1;

  // Control bits and owner of the operation held between accept and response
  typedef struct packed {
    logic ctl0;
    logic ctl1;
    logic id;
  } op_tag_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the requester that did not win last time is chosen.
module rr_pick2 (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic gnt,
  output logic id
);

  always_comb begin
    gnt = v0 | v1;
    id  = (v0 && v1) ? ~last : v1;
  end

endmodule

// File: rtl/shifter.sv
// Combinational shifter datapath; b is used at full width, so amounts >= WIDTH fully drain or sign-fill.
module shifter
  import shifter_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctl0,
  input  logic             ctl1
);

  always_comb begin
    out = a << b;
    if (ctl1 == CTL_LEFT) begin
      out = a << b;
    end else if (ctl0 == CTL_ARITH) begin
      out = WIDTH'($signed(a) >>> b);
    end else begin
      out = a >> b;
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters with a tagged registered response.
// Define SHIFTER_ARB_PERF_EN to add saturating per-requester grant counters.
module shifter_arbiter
  import shifter_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ctl0,
  input  logic             req0_ctl1,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ctl0,
  input  logic             req1_ctl1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
`ifdef SHIFTER_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] grant_count0,
  output logic [CNT_W-1:0] grant_count1
`endif
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_tag_t          tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             gnt, gnt_id;
  logic [WIDTH-1:0] shift_out;

  rr_pick2 u_pick (
    .v0   (req0_valid),
    .v1   (req1_valid),
    .last (last_grant_q),
    .gnt  (gnt),
    .id   (gnt_id)
  );

  shifter #(.WIDTH(WIDTH)) u_shifter (
    .out  (shift_out),
    .a    (a_q),
    .b    (b_q),
    .ctl0 (tag_q.ctl0),
    .ctl1 (tag_q.ctl1)
  );

  // Next-state and handshake logic; ready is suppressed while reset is asserted
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt && !reset) begin
          req0_ready   = ~gnt_id;
          req1_ready   = gnt_id;
          a_d          = gnt_id ? req1_a : req0_a;
          b_d          = gnt_id ? req1_b : req0_b;
          tag_d.ctl0   = gnt_id ? req1_ctl0 : req0_ctl0;
          tag_d.ctl1   = gnt_id ? req1_ctl1 : req0_ctl1;
          tag_d.id     = gnt_id;
          last_grant_d = gnt_id;
          state_d      = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        rsp_data_d  = shift_out;
        rsp_id_d    = tag_q.id;
        rsp_valid_d = 1'b1;
        state_d     = ARB_RESP;
      end
      ARB_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef SHIFTER_ARB_PERF_EN
  logic [CNT_W-1:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;

  always_comb begin
    gcnt0_d = req0_ready ? sat_inc(gcnt0_q) : gcnt0_q;
    gcnt1_d = req1_ready ? sat_inc(gcnt1_q) : gcnt1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  assign grant_count0 = gcnt0_q;
  assign grant_count1 = gcnt1_q;
`endif

endmodule
